// File: rtl/alu_pkg.sv
// Shared ALU control-code table, execute FSM encoding and code helpers.
// Used by both the ALU-control decoder and alu_exec_unit.
package alu_pkg;

  typedef logic [3:0] alu_ctl_t;

  localparam alu_ctl_t ALU_AND  = 4'b0000;
  localparam alu_ctl_t ALU_OR   = 4'b0001;
  localparam alu_ctl_t ALU_ADD  = 4'b0010;
  localparam alu_ctl_t ALU_XOR  = 4'b0011;
  localparam alu_ctl_t ALU_SUB  = 4'b0110;
  localparam alu_ctl_t ALU_SLT  = 4'b0111;
  localparam alu_ctl_t ALU_SLL  = 4'b1000;
  localparam alu_ctl_t ALU_SRL  = 4'b1001;
  localparam alu_ctl_t ALU_SRA  = 4'b1010;
  localparam alu_ctl_t ALU_SLTU = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input alu_ctl_t code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/result handshake bundle for alu_exec_unit.
// master = operand-fetch / writeback side, slave = the execute unit.
interface alu_exec_unit_if
  import alu_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  alu_ctl_t        alu_ctl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_ctl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_ctl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_op_core.sv
// Purely combinational single-cycle ALU ops with undefined-code detection.
// ALU_EXEC_BARREL_SHIFT_EN adds a barrel shifter; otherwise shifts pass op_a (shift by zero).
module alu_op_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_ctl_t        alu_ctl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result,
  output logic            illegal
);
  localparam int SHAMT_W = $clog2(XLEN);

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    result  = '0;
    illegal = 1'b0;
    case (alu_ctl)
      ALU_AND:  result = op_a & op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_ADD:  result = op_a + op_b;
      ALU_XOR:  result = op_a ^ op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_SLT:  result = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: result = XLEN'(op_a < op_b);
`ifdef ALU_EXEC_BARREL_SHIFT_EN
      ALU_SLL:  result = op_a << op_b[SHAMT_W-1:0];
      ALU_SRL:  result = op_a >> op_b[SHAMT_W-1:0];
      ALU_SRA:  result = XLEN'($signed(op_a) >>> op_b[SHAMT_W-1:0]);
`else
      // Only the shamt == 0 case reaches this path; non-zero shifts iterate in the top.
      ALU_SLL, ALU_SRL, ALU_SRA: result = op_a;
`endif
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage: IDLE/SHIFT/DONE FSM, bit-serial shifter, registered result.
// Define ALU_EXEC_BARREL_SHIFT_EN to make every op single-cycle via a barrel shifter.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_exec_unit_if.slave   bus
);
  localparam int SHAMT_W = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] core_result;
  logic            core_illegal;
  logic            accept;
  logic            start_shift;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            illegal_q;
  logic            out_valid_q;

  alu_op_core #(.XLEN(XLEN)) u_core (
    .alu_ctl (bus.alu_ctl),
    .op_a    (bus.op_a),
    .op_b    (bus.op_b),
    .result  (core_result),
    .illegal (core_illegal)
  );

  assign accept = bus.in_valid && (state_q == ST_IDLE);

`ifdef ALU_EXEC_BARREL_SHIFT_EN
  assign start_shift = 1'b0;
`else
  logic [SHAMT_W-1:0] shamt;
  logic [SHAMT_W-1:0] cnt_q;
  logic [XLEN-1:0]    acc_q;
  logic [XLEN-1:0]    acc_next;
  alu_ctl_t           shift_ctl_q;

  function automatic logic [XLEN-1:0] shift1(input alu_ctl_t ctl, input logic [XLEN-1:0] v);
    case (ctl)
      ALU_SLL: return {v[XLEN-2:0], 1'b0};
      ALU_SRA: return {v[XLEN-1], v[XLEN-1:1]};
      default: return {1'b0, v[XLEN-1:1]};
    endcase
  endfunction

  assign shamt       = bus.op_b[SHAMT_W-1:0];
  assign start_shift = accept && is_shift(bus.alu_ctl) && (shamt != '0);
  assign acc_next    = shift1(shift_ctl_q, acc_q);
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = start_shift ? ST_SHIFT : ST_DONE;
`ifndef ALU_EXEC_BARREL_SHIFT_EN
      ST_SHIFT: if (cnt_q == SHAMT_W'(1)) state_d = ST_DONE;
`endif
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output flags come straight from flops so branch resolve never sees a glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_d == ST_DONE);
      if (accept && !start_shift) begin
        result_q  <= core_result;
        zero_q    <= (core_result == '0);
        illegal_q <= core_illegal;
      end
`ifndef ALU_EXEC_BARREL_SHIFT_EN
      else if ((state_q == ST_SHIFT) && (cnt_q == SHAMT_W'(1))) begin
        result_q  <= acc_next;
        zero_q    <= (acc_next == '0);
        illegal_q <= 1'b0;
      end
`endif
    end
  end

`ifndef ALU_EXEC_BARREL_SHIFT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      shift_ctl_q <= ALU_AND;
    end else if (start_shift) begin
      acc_q       <= bus.op_a;
      cnt_q       <= shamt;
      shift_ctl_q <= bus.alu_ctl;
    end else if (state_q == ST_SHIFT) begin
      acc_q <= acc_next;
      cnt_q <= cnt_q - SHAMT_W'(1);
    end
  end
`endif

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results queued at issue, compared on completion.
// Expected latency follows ALU_EXEC_BARREL_SHIFT_EN when it is defined for the build.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checked = 0;
  int   n_failed  = 0;
  int   hs_count  = 0;
  int   last_lat  = 0;
  exp_t sb[$];

  alu_exec_unit_if #(.XLEN(XLEN)) bus ();

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) hs_count++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checked++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input alu_ctl_t c, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [4:0]  sh;
    logic [31:0] r;
    logic        ill;
    sh  = b[4:0];
    r   = 32'h0;
    ill = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = a ^ b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: r = a << sh;
      4'b1001: r = a >> sh;
      4'b1010: r = 32'($signed(a) >>> sh);
      4'b1011: r = (a < b) ? 32'd1 : 32'd0;
      default: ill = 1'b1;
    endcase
    e.result  = r;
    e.zero    = (r == 32'h0);
    e.illegal = ill;
`ifdef ALU_EXEC_BARREL_SHIFT_EN
    e.lat = 1;
`else
    e.lat = ((c == 4'b1000 || c == 4'b1001 || c == 4'b1010) && sh != 5'd0) ? int'(sh) + 1 : 1;
`endif
    return e;
  endfunction

  // Drives one request, waits for acceptance, then measures edges until out_valid.
  task automatic issue(input alu_ctl_t c, input logic [31:0] a, input logic [31:0] b);
    int guard;
    sb.push_back(model(c, a, b));
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alu_ctl  = c;
    bus.op_a     = a;
    bus.op_b     = b;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("accept_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.alu_ctl  = alu_ctl_t'($urandom_range(0, 15));
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
    last_lat = 1;
    while (!bus.out_valid && last_lat < 100) begin
      @(posedge clk);
      #1;
      last_lat++;
    end
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   hs0;
    e = sb.pop_front();
    check("out_valid", 32'(bus.out_valid), 32'd1);
    check("result", bus.result, e.result);
    check("zero", 32'(bus.zero), 32'(e.zero));
    check("illegal", 32'(bus.illegal), 32'(e.illegal));
    check("latency", 32'(last_lat), 32'(e.lat));
    hs0 = hs_count;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = i[0];
      bus.alu_ctl  = ALU_ADD;
      @(posedge clk);
      #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_result", bus.result, e.result);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_valid", 32'(bus.out_valid), 32'd0);
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_result", bus.result, e.result);
    check("handshakes", 32'(hs_count - hs0), 32'd1);
  endtask

  task automatic run(input alu_ctl_t c, input logic [31:0] a, input logic [31:0] b, input int hold);
    bus.out_ready = (hold == 0);
    issue(c, a, b);
    collect(hold);
  endtask

  initial begin
    alu_ctl_t legal [10];
    alu_ctl_t c;
    legal = '{ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB,
              ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLTU};
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_ctl   = ALU_AND;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.result, 32'h0);
    check("rst_zero", 32'(bus.zero), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);

    run(ALU_ADD,  32'h7FFF_FFFF, 32'h1, 0);
    run(ALU_SUB,  32'd5, 32'd5, 0);
    run(ALU_SLT,  32'hFFFF_FFFF, 32'h1, 0);
    run(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 0);
    run(ALU_SRA,  32'h8000_0000, 32'd31, 0);
    run(ALU_SLL,  32'hDEAD_BEEF, 32'd0, 0);
    run(ALU_SLL,  32'h1, 32'd4, 5);
    run(ALU_SRL,  32'hF000_000F, 32'd3, 0);
    run(4'b0100,  32'h1234_5678, 32'h1, 0);
    run(ALU_OR,   32'h0, 32'h0, 0);
    run(ALU_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 0);

    for (int i = 0; i < 12; i++) begin
      c = legal[$urandom_range(0, 9)];
      run(c, $urandom, $urandom, (i % 4 == 3) ? 2 : 0);
    end
    run(ALU_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 0);

    // Reset in the middle of a long shift; the op must vanish.
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alu_ctl  = ALU_SRL;
    bus.op_a     = 32'hF0F0_0000;
    bus.op_b     = 32'd20;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_result", bus.result, 32'h0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_zero", 32'(bus.zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("postrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("postrst_in_ready", 32'(bus.in_ready), 32'd1);
    run(ALU_ADD, 32'd2, 32'd3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_failed);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execution-side consumer of the 4-bit ALU control code produced by ALU-control decode. Takes the control code plus two operands over a valid/ready handshake. Logic ops, ADD, SUB and compares complete in one cycle. Shifts iterate one bit per cycle. Returns a registered result and zero flag over a second valid/ready handshake. Sits between operand fetch and writeback/branch resolve in the multi-cycle execute path.

Parameters:
XLEN, 32, operand/result width; shift amount width SHAMT_W = $clog2(XLEN) (derived localparam, 5 at default)

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  operation request valid
in_ready  out  1  unit can accept; high only in IDLE
alu_ctl  in  4  ALU control code
op_a  in  XLEN  operand A (shift source)
op_b  in  XLEN  operand B (shift amount = op_b[SHAMT_W-1:0])
out_valid  out  1  result valid; high only in DONE
out_ready  in  1  consumer accepts result
result  out  XLEN  registered result
zero  out  1  registered (result == 0), for branch resolve
illegal  out  1  registered; alu_ctl was not a defined code

Behaviour:
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT (signed, result 0/1), 1000 SLL, 1001 SRL, 1010 SRA, 1011 SLTU (unsigned, result 0/1).
- Any other code gives result 0, zero 1, illegal 1, with single-cycle latency.
- ADD/SUB wrap modulo 2^XLEN; no overflow flag.
- FSM states: IDLE, SHIFT, DONE.
- Acceptance: in_valid && in_ready at a rising edge E. alu_ctl, op_a and shamt are captured at E; inputs are don't-care afterwards.
- IDLE -> DONE at E for a non-shift op, or a shift with shamt=0. Result is computed combinationally and registered, so latency is 1 cycle.
- IDLE -> SHIFT at E for a shift with shamt=N>0: acc <= op_a, cnt <= N.
- In SHIFT, each edge shifts acc by 1 (SLL: left, zero fill; SRL: right, zero fill; SRA: right, sign fill) and decrements cnt.
- SHIFT -> DONE on the edge where cnt goes 1->0; result <= shifted value. Latency is N+1 cycles, N<=XLEN-1.
- DONE holds result/zero/illegal stable until out_ready. out_valid && out_ready -> IDLE.
- No accept in DONE, so throughput is at most one op per 2 cycles.
- out_valid, zero and illegal are glitch-free registers. result is unchanged between DONE exit and the next completion.
- Reset (rst_n low at any edge, including mid-SHIFT or DONE): state IDLE, in-flight op discarded, out_valid 0, result 0, zero 0, illegal 0, cnt 0, acc 0. in_ready is 1 the first cycle after reset release.
- in_valid low in IDLE: no state change.
- out_ready high outside DONE is ignored.

Optional Feature:
Macro ALU_EXEC_BARREL_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter and always take the IDLE->DONE path; SHIFT state and cnt are not built. Latency is 1 for all ops.
- Undefined: iterative shifter as described above.
- Handshake, reset and result values are identical in both builds.

Decomposition:
- Shared package alu_pkg: ALU control code localparams (ALU_AND ... ALU_SLTU), FSM state encoding, a helper function is_shift(code).
- The package is shared with the ALU-control decoder so both ends use one code table.
- One sub-module, alu_op_core: purely combinational single-cycle ops (logic/ADD/SUB/SLT/SLTU, plus barrel shift when the macro is defined) with an illegal output.
- alu_exec_unit holds the FSM, handshakes, shift iteration and output registers.

Test Plan:
- ADD, a=0x7FFFFFFF, b=1, out_ready=1 -> out_valid 1 cycle after acceptance, result 0x80000000, zero 0; in_ready back to 1 the following cycle.
- SUB, a=5, b=5 -> result 0, zero 1. SLT a=0xFFFFFFFF, b=1 -> result 1. SLTU with the same operands -> result 0.
- SRA, a=0x80000000, b=31 -> out_valid after 32 cycles (iterative) or 1 cycle (macro), result 0xFFFFFFFF. SLL with b=0 -> 1-cycle latency, result = a.
- Backpressure: SLL a=1, b=4, out_ready low for 5 cycles after DONE -> result 0x10 held stable; in_ready 0 throughout; in_valid pulses ignored; one handshake on release.
- Reset mid-SHIFT (SRL, b=20, rst_n low at cycle 8) -> next cycle out_valid 0, result 0, in_ready 1; subsequent ADD 2+3 returns 5.
- Illegal code 0100 -> result 0, zero 1, illegal 1, latency 1; next legal op clears illegal.
